vram_write_sched: RTL

VRAM_WRITE_SCHED -- requirements
Module: vram_write_sched

---
 rtl/vram_write_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vram_write_sched.sv
// Text-mode VRAM write scheduler: queues CPU cell writes, issues them during blanking,
// and can fill the whole screen with a clear character and color.
module vram_write_sched #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         COLS       = 80,
  parameter int         ROWS       = 25,
  parameter logic [7:0] CLR_CHAR   = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_char,
  input  logic [7:0]  wr_colr,
  input  logic        clr_start,
  input  logic [7:0]  clr_colr,
  input  logic        blank,
  output logic [11:0] ram_wraddr,
  output logic [7:0]  ram_chr,
  output logic [7:0]  ram_colr,
  output logic        ram_wren,
  output logic        busy,
  output logic        clr_done,
  output logic [7:0]  drop_cnt
);

  localparam int                PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]        COLS_L   = 8'(COLS);
  localparam logic [5:0]        ROWS_L   = 6'(ROWS);
  localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t state, state_next;

  logic [11:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]  fifo_chr  [FIFO_DEPTH];
  logic [7:0]  fifo_colr [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;

  logic        push, pop, in_range;
  logic        clr_accept, clr_issue, last_cell, clear_enter;
  logic        clr_fin;
  logic [6:0]  clr_col;
  logic [4:0]  clr_row;
  logic [7:0]  clr_color;
  logic [11:0] head_addr;
  logic [7:0]  head_chr, head_colr;

  assign head_addr = fifo_addr[rd_ptr];
  assign head_chr  = fifo_chr[rd_ptr];
  assign head_colr = fifo_colr[rd_ptr];

  assign wr_ready    = !rst && (state == IDLE) && (count != FULL_CNT);
  assign push        = wr_valid && wr_ready;
  assign pop         = (count != '0) && blank && ((state == IDLE) || (state == DRAIN));
  assign count_next  = count + CNT_W'(push) - CNT_W'(pop);
  assign in_range    = ({1'b0, head_addr[6:0]} < COLS_L) && ({1'b0, head_addr[11:7]} < ROWS_L);
  assign clr_accept  = clr_start && (state == IDLE);
  assign clr_issue   = (state == CLEAR) && !clr_fin && blank;
  assign last_cell   = (clr_row == LAST_ROW) && (clr_col == LAST_COL);
  assign clear_enter = (state != CLEAR) && (state_next == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A clear that arrives with writes still queued (including one pushed on the
  // same edge) drains them first so the clear really is the last word on screen.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clr_accept) state_next = (count_next == '0) ? CLEAR : DRAIN;
      end
      DRAIN: begin
        if (count_next == '0) state_next = CLEAR;
      end
      CLEAR: begin
        if (clr_fin) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= wr_addr;
        fifo_chr[wr_ptr]  <= wr_char;
        fifo_colr[wr_ptr] <= wr_colr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Raster position only advances on an issued write, so blank=0 simply freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_row   <= '0;
      clr_col   <= '0;
      clr_fin   <= 1'b0;
      clr_color <= '0;
    end else begin
      if (clr_accept) clr_color <= clr_colr;
      if (clear_enter) begin
        clr_row <= '0;
        clr_col <= '0;
        clr_fin <= 1'b0;
      end else if (clr_issue) begin
        if (last_cell) begin
          clr_fin <= 1'b1;
        end else if (clr_col == LAST_COL) begin
          clr_col <= '0;
          clr_row <= clr_row + 1'b1;
        end else begin
          clr_col <= clr_col + 1'b1;
        end
      end else if ((state == CLEAR) && clr_fin) begin
        clr_fin <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wren   <= 1'b0;
      ram_wraddr <= '0;
      ram_chr    <= '0;
      ram_colr   <= '0;
      busy       <= 1'b0;
      clr_done   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      ram_wren <= 1'b0;
      clr_done <= 1'b0;
      if (pop) begin
        if (in_range) begin
          ram_wren   <= 1'b1;
          ram_wraddr <= head_addr;
          ram_chr    <= head_chr;
          ram_colr   <= head_colr;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (clr_issue) begin
        ram_wren   <= 1'b1;
        ram_wraddr <= {clr_row, clr_col};
        ram_chr    <= CLR_CHAR;
        ram_colr   <= clr_color;
      end
      if (clr_accept) begin
        busy <= 1'b1;
      end else if ((state == CLEAR) && clr_fin) begin
        busy     <= 1'b0;
        clr_done <= 1'b1;
      end
    end
  end

endmodule
